// File: rtl/ahblite_busmatrix_outputstage_rr.sv
// AHB-Lite bus-matrix output stage: arbitrates NUM_PORTS input stages onto one slave,
// with burst locking, fixed-priority or round-robin selection and data-phase owner tracking.
module ahblite_busmatrix_outputstage_rr #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = 1
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [NUM_PORTS-1:0]          HSEL_IN,
    input  logic [NUM_PORTS*ADDR_W-1:0]   HADDR_IN,
    input  logic [2*NUM_PORTS-1:0]        HTRANS_IN,
    input  logic [NUM_PORTS-1:0]          HWRITE_IN,
    input  logic [3*NUM_PORTS-1:0]        HSIZE_IN,
    input  logic [3*NUM_PORTS-1:0]        HBURST_IN,
    input  logic [4*NUM_PORTS-1:0]        HPROT_IN,
    input  logic [NUM_PORTS*DATA_W-1:0]   HWDATA_IN,
    input  logic [NUM_PORTS-1:0]          TRANS_HOLD_IN,
    input  logic                          HREADYOUT,
    output logic [NUM_PORTS-1:0]          ACTIVE,
    output logic                          HSEL,
    output logic [ADDR_W-1:0]             HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [3:0]                    HPROT,
    output logic                          HREADY,
    output logic [DATA_W-1:0]             HWDATA
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
    localparam bit   RR_MODE      = (ARB_MODE != 32'sd0);
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'b000;

    // (base + step) modulo NUM_PORTS, step in 1..NUM_PORTS
    function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base, input int step);
        int sum_v;
        sum_v = int'(base) + step;
        return (sum_v >= NUM_PORTS) ? IDX_W'(sum_v - NUM_PORTS) : IDX_W'(sum_v);
    endfunction

    logic                  grant_valid_r;
    logic [IDX_W-1:0]      grant_idx_r;
    logic                  data_valid_r;
    logic [IDX_W-1:0]      data_idx_r;
    logic [IDX_W-1:0]      rr_ptr_r;

    logic [NUM_PORTS-1:0]  req_s;
    logic                  any_req_s;
    logic [NUM_PORTS-1:0]  grant_onehot_s;
    logic [NUM_PORTS-1:0]  data_onehot_s;
    logic                  hsel_s;
    logic [ADDR_W-1:0]     haddr_s;
    logic [1:0]            htrans_s;
    logic                  hwrite_s;
    logic [2:0]            hsize_s;
    logic [2:0]            hburst_s;
    logic [3:0]            hprot_s;
    logic [DATA_W-1:0]     hwdata_s;
    logic                  hready_s;
    logic                  burst_cont_s;
    logic                  lock_s;
    logic [IDX_W-1:0]      fixed_idx_s;
    logic [IDX_W-1:0]      rr_idx_s;
    logic [IDX_W-1:0]      win_idx_s;

    assign req_s     = HSEL_IN & TRANS_HOLD_IN;
    assign any_req_s = |req_s;

    // Address-phase mux: AND-OR select of the granted port, all zero when nobody owns the bus
    always_comb begin
        grant_onehot_s = '0;
        hsel_s         = 1'b0;
        haddr_s        = '0;
        htrans_s       = 2'b00;
        hwrite_s       = 1'b0;
        hsize_s        = 3'b000;
        hburst_s       = 3'b000;
        hprot_s        = 4'b0000;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_onehot_s[i] = grant_valid_r & (grant_idx_r == IDX_W'(i));
            hsel_s   = hsel_s   | (HSEL_IN[i]   & grant_onehot_s[i]);
            hwrite_s = hwrite_s | (HWRITE_IN[i] & grant_onehot_s[i]);
            haddr_s  = haddr_s  | (HADDR_IN[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_onehot_s[i]}});
            htrans_s = htrans_s | (HTRANS_IN[i*2 +: 2] & {2{grant_onehot_s[i]}});
            hsize_s  = hsize_s  | (HSIZE_IN[i*3 +: 3]  & {3{grant_onehot_s[i]}});
            hburst_s = hburst_s | (HBURST_IN[i*3 +: 3] & {3{grant_onehot_s[i]}});
            hprot_s  = hprot_s  | (HPROT_IN[i*4 +: 4]  & {4{grant_onehot_s[i]}});
        end
    end

    // Write-data mux follows the data-phase owner, which lags the address owner by one beat
    always_comb begin
        data_onehot_s = '0;
        hwdata_s      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            data_onehot_s[i] = data_valid_r & (data_idx_r == IDX_W'(i));
            hwdata_s = hwdata_s | (HWDATA_IN[i*DATA_W +: DATA_W] & {DATA_W{data_onehot_s[i]}});
        end
    end

    assign hready_s = data_valid_r ? HREADYOUT : 1'b1;

    // A burst in progress keeps the bus until its owner stops requesting or finishes
    assign burst_cont_s = (htrans_s == TRANS_SEQ) | (htrans_s == TRANS_BUSY) |
                          ((htrans_s == TRANS_NONSEQ) & (hburst_s != BURST_SINGLE));
    assign lock_s = grant_valid_r & (|(req_s & grant_onehot_s)) & burst_cont_s;

    // Candidate winners; descending loops leave the first hit in search order
    always_comb begin
        fixed_idx_s = '0;
        rr_idx_s    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            fixed_idx_s = req_s[i] ? IDX_W'(i) : fixed_idx_s;
        end
        for (int k = NUM_PORTS; k >= 1; k--) begin
            rr_idx_s = req_s[rr_wrap(rr_ptr_r, k)] ? rr_wrap(rr_ptr_r, k) : rr_idx_s;
        end
    end

    assign win_idx_s = RR_MODE ? rr_idx_s : fixed_idx_s;

    // Address-phase grant and round-robin pointer, advanced only on accepted beats
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_valid_r <= 1'b0;
            grant_idx_r   <= '0;
            rr_ptr_r      <= LAST_IDX;
        end else if (hready_s && !lock_s) begin
            grant_valid_r <= any_req_s;
            if (any_req_s) begin
                grant_idx_r <= win_idx_s;
                rr_ptr_r    <= win_idx_s;
            end
        end
    end

    // Data-phase owner: the address owner of the beat just accepted
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_valid_r <= 1'b0;
            data_idx_r   <= '0;
        end else if (hready_s) begin
            data_valid_r <= hsel_s & grant_valid_r;
            data_idx_r   <= grant_idx_r;
        end
    end

    assign ACTIVE = grant_onehot_s;
    assign HSEL   = hsel_s;
    assign HADDR  = haddr_s;
    assign HTRANS = htrans_s;
    assign HWRITE = hwrite_s;
    assign HSIZE  = hsize_s;
    assign HBURST = hburst_s;
    assign HPROT  = hprot_s;
    assign HREADY = hready_s;
    assign HWDATA = hwdata_s;

endmodule
